// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: default widths and FSM encoding.
package sram_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Binary state encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_INST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // True in the states that own the memory port.
  function automatic logic in_service(input logic [1:0] st);
    return (st == ST_DATA) || (st == ST_INST);
  endfunction

endpackage

// File: rtl/sram_req_latch.sv
// Holding register for one SRAM-like request (strobes, address, write data).
// The arbiter drives the shared memory port straight from these registers.
module sram_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STRB_W-1:0] next_wen,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic [DATA_W-1:0] next_wdata,
  output logic [STRB_W-1:0] wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  // Capture the selected request whenever the arbiter starts a new access.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are plain flops (not a memory array), so resetting them is
      // cheap and guarantees the memory port reads all-zero out of reset.
      wen   <= '0;
      addr  <= '0;
      wdata <= '0;
    end else if (load) begin
      wen   <= next_wen;
      addr  <= next_addr;
      wdata <= next_wdata;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the CPU instruction and data SRAM-like ports onto one memory
// master port. Data has strict priority; each access holds the port until
// mem_ack, and the sequence ends with a single non-stalling DONE cycle.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // instruction side
  input  logic                inst_en,
  input  logic [DATA_W/8-1:0] inst_wen,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic [DATA_W-1:0]   inst_rdata,
  // data side
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                cpu_stall,
  // shared memory port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              ack;
  logic              load;
  logic              sel_inst;
  logic [STRB_W-1:0] lat_wen;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  // mem_req comes from the state register only; an ack outside service is ignored.
  assign mem_req = in_service(state);
  assign ack     = mem_ack & mem_req;

  // Next-state logic: data first, then any pending instruction fetch.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (data_en)      state_next = ST_DATA;
        else if (inst_en) state_next = ST_INST;
      end
      ST_DATA: if (ack) state_next = inst_en ? ST_INST : ST_DONE;
      ST_INST: if (ack) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decide when the holding register captures and which CPU port feeds it.
  always_comb begin
    load     = 1'b0;
    sel_inst = 1'b0;
    case (state)
      ST_IDLE: begin
        load     = data_en | inst_en;
        sel_inst = ~data_en;
      end
      ST_DATA: begin
        load     = ack & inst_en;
        sel_inst = 1'b1;
      end
      default: ;
    endcase
  end

  sram_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STRB_W (STRB_W)
  ) u_req_latch (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .next_wen   (sel_inst ? inst_wen   : data_wen),
    .next_addr  (sel_inst ? inst_addr  : data_addr),
    .next_wdata (sel_inst ? inst_wdata : data_wdata),
    .wen        (lat_wen),
    .addr       (lat_addr),
    .wdata      (lat_wdata)
  );

  assign mem_wr    = |lat_wen;
  assign mem_wstrb = lat_wen;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Latch read data on a completed read; writes never touch the rdata registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rdata <= '0;
      inst_rdata <= '0;
    end else if (ack && !mem_wr) begin
      if (state == ST_DATA) data_rdata <= mem_rdata;
      if (state == ST_INST) inst_rdata <= mem_rdata;
    end
  end

  // Stall while any enabled request is outstanding; DONE releases the CPU.
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      ST_IDLE: cpu_stall = inst_en | data_en;
      ST_DATA: cpu_stall = 1'b1;
      ST_INST: cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  sram_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .inst_en    (inst_en),
    .inst_wen   (inst_wen),
    .inst_addr  (inst_addr),
    .inst_wdata (inst_wdata),
    .inst_rdata (inst_rdata),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_en = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
    data_en = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    mem_ack = 0; mem_rdata = 0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_req",   {31'd0, mem_req},   32'd0);
    check("rst_wr",    {31'd0, mem_wr},    32'd0);
    check("rst_addr",  mem_addr,           32'd0);
    check("rst_irdata", inst_rdata,        32'd0);
    check("rst_drdata", data_rdata,        32'd0);

    // Spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("spur_req",    {31'd0, mem_req}, 32'd0);
    check("spur_stall",  {31'd0, cpu_stall}, 32'd0);
    check("spur_drdata", data_rdata, 32'd0);
    check("spur_irdata", inst_rdata, 32'd0);
    mem_ack = 1'b0;

    // Instruction read alone, ack on second request cycle
    inst_en = 1'b1; inst_wen = 4'h0; inst_addr = 32'hBFC00000;
    #1;
    check("i_idle_stall", {31'd0, cpu_stall}, 32'd1);
    check("i_idle_req",   {31'd0, mem_req},   32'd0);
    tick();
    check("i_req1",  {31'd0, mem_req}, 32'd1);
    check("i_addr1", mem_addr, 32'hBFC00000);
    check("i_wr1",   {31'd0, mem_wr}, 32'd0);
    tick();
    check("i_req2",  {31'd0, mem_req}, 32'd1);
    check("i_addr2", mem_addr, 32'hBFC00000);
    mem_ack = 1'b1; mem_rdata = 32'h24080001;
    tick();
    mem_ack = 1'b0;
    check("i_done_req",   {31'd0, mem_req},   32'd0);
    check("i_done_stall", {31'd0, cpu_stall}, 32'd0);
    check("i_done_rdata", inst_rdata, 32'h24080001);
    inst_en = 1'b0;
    tick();
    check("i_back_idle", {31'd0, cpu_stall}, 32'd0);

    // Simultaneous data read + inst read, immediate acks
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80000010;
    inst_en = 1'b1; inst_wen = 4'h0; inst_addr = 32'hBFC00004;
    #1;
    check("s_idle_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("s_d_req",   {31'd0, mem_req}, 32'd1);
    check("s_d_addr",  mem_addr, 32'h80000010);
    check("s_d_stall", {31'd0, cpu_stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    check("s_i_req",    {31'd0, mem_req}, 32'd1);
    check("s_i_addr",   mem_addr, 32'hBFC00004);
    check("s_i_stall",  {31'd0, cpu_stall}, 32'd1);
    check("s_d_rdata",  data_rdata, 32'h11111111);
    mem_rdata = 32'h22222222;
    tick();
    mem_ack = 1'b0;
    check("s_done_stall", {31'd0, cpu_stall}, 32'd0);
    check("s_done_irdata", inst_rdata, 32'h22222222);
    check("s_done_drdata", data_rdata, 32'h11111111);
    data_en = 1'b0; inst_en = 1'b0;
    tick();

    // Byte write on the data side
    data_en = 1'b1; data_wen = 4'b0010; data_addr = 32'h80000020; data_wdata = 32'h0000AB00;
    tick();
    check("w_req",   {31'd0, mem_req}, 32'd1);
    check("w_wr",    {31'd0, mem_wr},  32'd1);
    check("w_strb",  {28'd0, mem_wstrb}, 32'h2);
    check("w_wdata", mem_wdata, 32'h0000AB00);
    check("w_addr",  mem_addr, 32'h80000020);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    check("w_done_stall",  {31'd0, cpu_stall}, 32'd0);
    check("w_done_drdata", data_rdata, 32'h11111111);
    data_en = 1'b0; data_wen = 4'h0;
    tick();

    // Instruction-side write leaves inst_rdata alone
    inst_en = 1'b1; inst_wen = 4'hF; inst_addr = 32'hBFC00008; inst_wdata = 32'h12345678;
    tick();
    check("iw_strb", {28'd0, mem_wstrb}, 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    check("iw_irdata", inst_rdata, 32'h22222222);
    inst_en = 1'b0; inst_wen = 4'h0;
    tick();

    // Reset in the middle of a data access
    data_en = 1'b1; data_addr = 32'h80000030;
    tick();
    check("r_req_before", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("r_req_now",  {31'd0, mem_req}, 32'd0);
    check("r_addr",     mem_addr, 32'd0);
    check("r_drdata",   data_rdata, 32'd0);
    check("r_irdata",   inst_rdata, 32'd0);
    check("r_stall_en", {31'd0, cpu_stall}, 32'd1);
    data_en = 1'b0;
    #1;
    check("r_stall_off", {31'd0, cpu_stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("r_after_req", {31'd0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of every port.
REQ-002 Parameter DATA_W, default 32, data width of every port; byte strobes are DATA_W/8 bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 inst_en, inst_wen[3:0], inst_addr, inst_wdata  input  1/4/ADDR_W/DATA_W  CPU instruction-side SRAM-like request.
REQ-006 inst_rdata  output  DATA_W  instruction read data returned to CPU.
REQ-007 data_en, data_wen[3:0], data_addr, data_wdata  input  1/4/ADDR_W/DATA_W  CPU data-side SRAM-like request; wen==0 means read.
REQ-008 data_rdata  output  DATA_W  data read data returned to CPU.
REQ-009 cpu_stall  output  1  high while any enabled CPU request in the current cycle is not yet complete.
REQ-010 mem_req, mem_wr, mem_wstrb[3:0], mem_addr, mem_wdata  output  1/1/4/ADDR_W/DATA_W  single shared memory master port.
REQ-011 mem_ack, mem_rdata  input  1/DATA_W  memory completion strobe and read data, valid together.

Function
REQ-012 FSM states: IDLE, DATA, INST, DONE; one-hot or binary at implementer's choice.
REQ-013 IDLE: if data_en, capture data request, go DATA; else if inst_en, capture inst request, go INST; else stay IDLE.
REQ-014 While in IDLE, cpu_stall = inst_en | data_en (combinational); zero-enable cycles do not stall.
REQ-015 Captured fields (addr, wdata, wen) are registered; mem_* outputs are driven only from registers and stay stable until mem_ack.
REQ-016 mem_req is high in DATA and INST only; first asserted the cycle after capture (latency 1).
REQ-017 mem_wr = |captured wen; mem_wstrb = captured wen.
REQ-018 mem_ack counts only while mem_req is high; mem_ack in IDLE/DONE is ignored.
REQ-019 DATA + mem_ack: if read, latch mem_rdata into data_rdata; then go INST (capturing inst request) if inst_en pending, else DONE.
REQ-020 INST + mem_ack: latch mem_rdata into inst_rdata (writes leave it unchanged); go DONE.
REQ-021 Data has strict priority; instruction request serviced only after data request completes.
REQ-022 cpu_stall high in DATA and INST, low in DONE; DONE lasts exactly one cycle, then IDLE.
REQ-023 Write transactions never modify data_rdata or inst_rdata.
REQ-024 data_rdata/inst_rdata hold last latched value until next matching read completes.
REQ-025 mem_ack on the first mem_req cycle is legal; minimum service time 1 cycle per access.
REQ-026 Address wrap: no arithmetic on addresses; forwarded unchanged.

Reset
REQ-027 On rst high: state IDLE, mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, inst_rdata 0, data_rdata 0, immediately (asynchronous).
REQ-028 rst asserted mid-transaction abandons it; mem_req drops in the same cycle; no data latched.
REQ-029 cpu_stall after reset follows REQ-014.

Structure
REQ-030 FSM state encoding and ADDR_W/DATA_W defaults live in the shared cpu package/defines file.
REQ-031 One sub-module is natural: sram_req_latch (captures en/wen/addr/wdata into holding register), instantiated once and muxed by state.

Verification
REQ-032 Reset then idle: rst pulse, inst_en=data_en=0 -> cpu_stall=0, mem_req=0, all rdata 0.
REQ-033 Inst read alone: inst_en=1, inst_addr=0xBFC00000, mem_ack after 2 cycles with rdata 0x24080001 -> mem_req for 2 cycles at that address, inst_rdata=0x24080001 in DONE, cpu_stall low in DONE.
REQ-034 Simultaneous: data_en=1 wen=0 addr=0x80000010, inst_en=1 addr=0xBFC00004, immediate acks rdata 0x11111111 then 0x22222222 -> data issued first, data_rdata=0x11111111, inst_rdata=0x22222222, stall 3 cycles total.
REQ-035 Byte write: data_en=1 wen=4'b0010 wdata=0x0000AB00 -> mem_wr=1, mem_wstrb=0010, data_rdata unchanged after ack.
REQ-036 Reset mid-access: rst asserted in DATA before mem_ack -> mem_req 0 same cycle, state IDLE, data_rdata 0.
REQ-037 Spurious ack: mem_ack=1 with mem_req=0 in IDLE -> no state change, rdata unchanged.
